// File: rtl/nx_fifo_rd_stream_adapter.sv
// Drains a fixed-latency FIFO read port into a valid/ready stream through a
// small credit-managed buffer, with synchronous flush and debug counters.
module nx_fifo_rd_stream_adapter #(
  parameter int N_DATA_BITS = 32,
  parameter int RD_LATENCY  = 1,
  parameter int BUF_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd,
  input  logic [N_DATA_BITS-1:0] fifo_rd_data,
  output logic                   out_valid,
  output logic [N_DATA_BITS-1:0] out_data,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic                   busy,
  output logic [15:0]            pop_cnt,
  output logic [7:0]             discard_cnt
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int IFC_W = $clog2(RD_LATENCY + 1);
  localparam int CNT_W = $clog2(BUF_DEPTH + RD_LATENCY + 2);

  function automatic logic [IFC_W-1:0] popcnt(input logic [RD_LATENCY-1:0] v);
    logic [IFC_W-1:0] s;
    s = '0;
    for (int i = 0; i < RD_LATENCY; i++) s = s + IFC_W'(v[i]);
    return s;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [CNT_W-1:0] b);
    int s;
    s = int'(a) + int'(b);
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  // Pointers wrap at BUF_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == BUF_DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  logic [N_DATA_BITS-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [OCC_W-1:0]       r_occ;
  logic [RD_LATENCY-1:0]  r_inflight;
  logic [15:0]            r_pop_cnt;
  logic [7:0]             r_discard_cnt;

  logic                   w_xfer;
  logic                   w_land;
  logic [IFC_W-1:0]       w_inflight_cnt;
  logic [CNT_W-1:0]       w_credit_used;
  logic [CNT_W-1:0]       w_credit_lim;
  logic [CNT_W-1:0]       w_discard_add;
  logic [RD_LATENCY-1:0]  w_inflight_nxt;

  assign out_valid      = (r_occ != '0);
  assign out_data       = out_valid ? r_mem[r_rptr] : '0;
  assign busy           = (r_occ != '0) || (r_inflight != '0);
  assign pop_cnt        = r_pop_cnt;
  assign discard_cnt    = r_discard_cnt;

  assign w_xfer         = out_valid && out_ready;
  assign w_land         = r_inflight[RD_LATENCY-1];
  assign w_inflight_cnt = popcnt(r_inflight);

  // A word leaving this cycle frees its slot for a pop issued this cycle.
  assign w_credit_used  = CNT_W'(r_occ) + CNT_W'(w_inflight_cnt);
  assign w_credit_lim   = CNT_W'(BUF_DEPTH) + CNT_W'(w_xfer);
  assign fifo_rd        = rst_n && !fifo_empty && !flush && (w_credit_used < w_credit_lim);

  // A transfer completing in the flush cycle is delivered, not discarded.
  assign w_discard_add  = CNT_W'(r_occ) - CNT_W'(w_xfer) + CNT_W'(w_inflight_cnt);

  always_comb begin
    w_inflight_nxt    = '0;
    w_inflight_nxt[0] = fifo_rd;
    for (int i = 1; i < RD_LATENCY; i++) w_inflight_nxt[i] = r_inflight[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_occ         <= '0;
      r_inflight    <= '0;
      r_pop_cnt     <= '0;
      r_discard_cnt <= '0;
    end else if (flush) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_occ         <= '0;
      r_inflight    <= '0;
      r_discard_cnt <= sat_add8(r_discard_cnt, w_discard_add);
    end else begin
      r_inflight <= w_inflight_nxt;
      if (fifo_rd) r_pop_cnt <= r_pop_cnt + 16'd1;
      if (w_land)  r_wptr    <= ptr_inc(r_wptr);
      if (w_xfer)  r_rptr    <= ptr_inc(r_rptr);
      case ({w_land, w_xfer})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Returns arriving during a flush are dropped along with the buffer.
  always_ff @(posedge clk) begin
    if (w_land && !flush) r_mem[r_wptr] <= fifo_rd_data;
  end

endmodule

// File: tb/tb_nx_fifo_rd_stream_adapter.sv
// Directed bench for nx_fifo_rd_stream_adapter: two instances (latency 1 /
// depth 2 and latency 2 / depth 3), each fed by a small behavioural FIFO.
module tb_nx_fifo_rd_stream_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: RD_LATENCY=1, BUF_DEPTH=2
  logic        rst_a_n = 1'b0;
  logic        empty_a, rd_a, vld_a, busy_a;
  logic        rdy_a = 1'b0, flush_a = 1'b0;
  logic [31:0] rdata_a, odata_a;
  logic [15:0] pcnt_a;
  logic [7:0]  dcnt_a;
  int          head_a = 0, tail_a = 0, start_a = 0;
  logic [31:0] base_a = 32'h0;

  assign empty_a = (head_a == tail_a);
  always @(posedge clk) begin
    if (rd_a) head_a <= head_a + 1;
    rdata_a <= base_a + 32'(head_a - start_a);
  end

  // Instance B: RD_LATENCY=2, BUF_DEPTH=3
  logic        rst_b_n = 1'b0;
  logic        empty_b, rd_b, vld_b, busy_b;
  logic        rdy_b = 1'b0, flush_b = 1'b0;
  logic [31:0] rdata_b, odata_b, db1;
  logic [15:0] pcnt_b;
  logic [7:0]  dcnt_b;
  int          head_b = 0, tail_b = 0, start_b = 0;
  logic [31:0] base_b = 32'h0;

  assign empty_b = (head_b == tail_b);
  always @(posedge clk) begin
    if (rd_b) head_b <= head_b + 1;
    db1     <= base_b + 32'(head_b - start_b);
    rdata_b <= db1;
  end

  nx_fifo_rd_stream_adapter #(.N_DATA_BITS(32), .RD_LATENCY(1), .BUF_DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_a_n), .fifo_empty(empty_a), .fifo_rd(rd_a),
    .fifo_rd_data(rdata_a), .out_valid(vld_a), .out_data(odata_a),
    .out_ready(rdy_a), .flush(flush_a), .busy(busy_a),
    .pop_cnt(pcnt_a), .discard_cnt(dcnt_a)
  );

  nx_fifo_rd_stream_adapter #(.N_DATA_BITS(32), .RD_LATENCY(2), .BUF_DEPTH(3)) u_b (
    .clk(clk), .rst_n(rst_b_n), .fifo_empty(empty_b), .fifo_rd(rd_b),
    .fifo_rd_data(rdata_b), .out_valid(vld_b), .out_data(odata_b),
    .out_ready(rdy_b), .flush(flush_b), .busy(busy_b),
    .pop_cnt(pcnt_b), .discard_cnt(dcnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Occupancy bound, checked every cycle on both instances.
  always @(negedge clk) begin
    checks++;
    assert (int'(u_a.r_occ) <= 2) else begin
      failures++;
      $error("FAIL occ_bound_a: observed=%0d expected<=2", u_a.r_occ);
    end
    checks++;
    assert (int'(u_b.r_occ) <= 3) else begin
      failures++;
      $error("FAIL occ_bound_b: observed=%0d expected<=3", u_b.r_occ);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_a(input logic [31:0] base, input int n);
    start_a = head_a;
    base_a  = base;
    tail_a  = head_a + n;
  endtask

  task automatic preload_b(input logic [31:0] base, input int n);
    start_b = head_b;
    base_b  = base;
    tail_b  = head_b + n;
  endtask

  // Holds reset with a non-empty FIFO, checks reset values, then releases.
  task automatic reset_a();
    rst_a_n = 1'b0; flush_a = 1'b0; rdy_a = 1'b0;
    preload_a(32'hDEAD0000, 1);
    cyc(); #1;
    chk("rstA_rd", rd_a, 0);
    chk("rstA_vld", vld_a, 0);
    chk("rstA_data", odata_a, 0);
    chk("rstA_busy", busy_a, 0);
    chk("rstA_pcnt", pcnt_a, 0);
    chk("rstA_dcnt", dcnt_a, 0);
    cyc();
    tail_a  = head_a;
    rst_a_n = 1'b1;
  endtask

  task automatic reset_b();
    rst_b_n = 1'b0; flush_b = 1'b0; rdy_b = 1'b0;
    preload_b(32'hBEEF0000, 1);
    cyc(); #1;
    chk("rstB_rd", rd_b, 0);
    chk("rstB_vld", vld_b, 0);
    chk("rstB_data", odata_b, 0);
    chk("rstB_busy", busy_b, 0);
    chk("rstB_pcnt", pcnt_b, 0);
    chk("rstB_dcnt", dcnt_b, 0);
    cyc();
    tail_b  = head_b;
    rst_b_n = 1'b1;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming: 8 words, out_ready high
    reset_a();
    reset_b();
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (c == 0) begin preload_a(32'h10, 8); rdy_a = 1'b1; end
      #1;
      chk("stream_rd", rd_a, (c < 8));
      chk("stream_vld", vld_a, (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) chk("stream_data", odata_a, 32'h10 + 32'(c - 2));
    end
    chk("stream_pcnt", pcnt_a, 8);

    // Back-pressure: out_ready low for cycles 0..9
    reset_a();
    for (int c = 0; c < 19; c++) begin
      cyc();
      if (c == 0) begin preload_a(32'h20, 8); rdy_a = 1'b0; end
      if (c == 10) rdy_a = 1'b1;
      #1;
      if (c < 10) chk("bp_rd", rd_a, (c < 2));
      if (c >= 3 && c < 10) chk("bp_hold_data", odata_a, 32'h20);
      if (c == 9) begin
        chk("bp_occ", 32'(u_a.r_occ), 2);
        chk("bp_vld", vld_a, 1);
        chk("bp_pcnt", pcnt_a, 2);
      end
      if (c >= 10 && c < 18) begin
        chk("bp_resume_vld", vld_a, 1);
        chk("bp_resume_data", odata_a, 32'h20 + 32'(c - 10));
      end
      if (c == 18) chk("bp_end_vld", vld_a, 0);
    end

    // Flush: latency 2, depth 3, occ=2 with one pop in flight
    for (int c = 0; c < 9; c++) begin
      cyc();
      if (c == 0) begin preload_b(32'h30, 8); rdy_b = 1'b0; end
      if (c == 4) flush_b = 1'b1;
      if (c == 5) begin flush_b = 1'b0; rdy_b = 1'b1; end
      #1;
      if (c <= 4) chk("fl_rd", rd_b, (c < 3));
      if (c == 4) begin
        chk("fl_pre_occ", 32'(u_b.r_occ), 2);
        chk("fl_pre_data", odata_b, 32'h30);
        chk("fl_pre_busy", busy_b, 1);
      end
      if (c == 5) begin
        chk("fl_dcnt", dcnt_b, 3);
        chk("fl_busy", busy_b, 0);
        chk("fl_pcnt", pcnt_b, 3);
      end
      if (c >= 5 && c <= 7) chk("fl_vld_low", vld_b, 0);
      if (c == 8) begin
        chk("fl_next_vld", vld_b, 1);
        chk("fl_next_data", odata_b, 32'h33);
      end
    end

    // Reset mid-flight on the latency-2 instance
    reset_b();
    for (int c = 0; c < 7; c++) begin
      cyc();
      if (c == 0) begin preload_b(32'h40, 1); rdy_b = 1'b0; end
      if (c == 1) rst_b_n = 1'b0;
      if (c == 2) rst_b_n = 1'b1;
      #1;
      if (c == 0) chk("mr_rd", rd_b, 1);
      if (c == 1) begin
        chk("mr_rd_rst", rd_b, 0);
        chk("mr_data", odata_b, 0);
        chk("mr_pcnt", pcnt_b, 0);
      end
      if (c >= 1) begin
        chk("mr_vld", vld_b, 0);
        chk("mr_busy", busy_b, 0);
      end
    end

    // Empty gating
    reset_a();
    rdy_a = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(); #1;
      chk("emp_rd", rd_a, 0);
      chk("emp_busy", busy_a, 0);
    end
    chk("emp_pcnt", pcnt_a, 0);

    // pop_cnt wrap after 65536 pops
    reset_a();
    cyc();
    preload_a(32'h1000, 65536);
    rdy_a = 1'b1;
    for (int c = 1; c <= 65535; c++) cyc();
    #1;
    chk("wrap_pcnt_max", pcnt_a, 16'hFFFF);
    chk("wrap_rd_last", rd_a, 1);
    cyc(); #1;
    chk("wrap_pcnt_zero", pcnt_a, 0);
    chk("wrap_rd_done", rd_a, 0);

    // discard_cnt saturation: each period pops once, then flushes one in-flight word
    reset_a();
    for (int p = 0; p < 300; p++) begin
      cyc();
      if (p == 0) begin preload_a(32'h0, 100000); rdy_a = 1'b0; end
      flush_a = 1'b0;
      #1;
      if (p == 0 || p == 100 || p == 255 || p == 256)
        chk("sat_dcnt", dcnt_a, (p > 255) ? 255 : p);
      cyc();
      flush_a = 1'b1;
      if (p == 0) begin #1; chk("sat_flush_rd", rd_a, 0); end
    end
    cyc();
    flush_a = 1'b0;
    #1;
    chk("sat_dcnt_final", dcnt_a, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
